cic_decim_scale_m256: RTL and testbench
=======================================

CIC_DECIM_SCALE_M256 -- requirements
Module: cic_decim_scale_M256

Interface
REQ-001 Parameter OUT_WIDTH, default 16: width of the signed output sample.
REQ-002 Parameter SHIFT_MAX, default 32: largest honoured right-shift.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 sync_reset  input  1  synchronous, active-high reset.
REQ-005 msetting  input  9  decimation factor; 0 and 1 both mean pass every sample; 256 is the maximum.
REQ-006 shift  input  6  right-shift applied before truncation; values above SHIFT_MAX are clamped to SHIFT_MAX.
REQ-007 s_axis_tvalid  input  1  qualifies s_axis_tdata; there is no ready, so the upstream comb output is never stalled.
REQ-008 s_axis_tdata  input  48  signed two's-complement comb output.
REQ-009 m_axis_tvalid  output  1  output sample valid.
REQ-010 m_axis_tdata  output  OUT_WIDTH  signed, rounded, saturated, decimated sample.
REQ-011 m_axis_tready  input  1  downstream ready; a transfer occurs when tvalid and tready are both 1.
REQ-012 overflow  output  1  sticky flag; set when a kept sample is dropped because the buffer is full.
REQ-013 sat_flag  output  1  sticky flag; set when any emitted sample was saturated.

Function
REQ-014 The phase counter shall count accepted input beats modulo max(msetting,1); it shall keep the beat where phase==0 and discard all others.
REQ-015 The phase counter shall restart at 0 on the cycle after msetting changes value; the first beat after that shall be kept.
REQ-016 Stage 1 (registered): for shift>0, add 2^(shift-1) in a 49-bit signed domain, then arithmetic-shift right by shift; for shift==0, the value shall pass unchanged.
REQ-017 Stage 2 (registered): saturate the 49-bit result to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-018 shift and msetting shall be sampled together with the beat they apply to; a change takes effect on the next accepted beat.
REQ-019 Latency: a kept beat at cycle t shall appear on m_axis with m_axis_tvalid=1 at cycle t+2 when the buffer is empty.
REQ-020 The output buffer shall be a 2-entry FIFO; m_axis_tdata shall be driven from the head entry.
REQ-021 m_axis_tdata and m_axis_tvalid shall stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-022 Buffer full with a push and no pop in the same cycle: the incoming sample shall be dropped, the contents left intact, and overflow set.
REQ-023 Buffer full with a push and a pop in the same cycle: both shall complete, the buffer shall stay full, and nothing shall be dropped.
REQ-024 Buffer empty with a push: m_axis_tvalid shall rise the next cycle; no bypass of the buffer is permitted.
REQ-025 Pipeline-stage valids shall advance unconditionally; only the buffer applies backpressure.
REQ-026 overflow and sat_flag shall clear only on sync_reset.

Reset
REQ-027 While sync_reset=1: m_axis_tvalid=0, m_axis_tdata=0, overflow=0, sat_flag=0, phase counter=0, buffer empty, and all stage valids=0.
REQ-028 Reset asserted mid-operation shall discard buffered and in-flight samples within one cycle; the first beat after release shall be kept.
REQ-029 Data-path registers without valids need no reset.

Structure
REQ-030 The saturation limits, the 49-bit intermediate width, and SHIFT_MAX shall live in a shared channelizer package.
REQ-031 The 2-entry buffer shall be one sub-module, axis_skid2, with parameter DATA_WIDTH; everything else stays in the top level.

Verification
REQ-032 msetting=4, shift=0, inputs 0..15 on consecutive cycles, tready=1 -> outputs 0,4,8,12, each exactly 2 cycles after its input.
REQ-033 shift=4, inputs 24, 23, -24, -25 with msetting=1 -> outputs 2 (round half up), 1, -1, -2.
REQ-034 shift=0, input 40000 then -40000 -> outputs 32767 then -32768, with sat_flag=1 afterwards.
REQ-035 msetting=1, tready=0, 3 valid beats -> first 2 held stable in the buffer, 3rd dropped, overflow=1; raise tready -> exactly the first 2 values come out, in order.
REQ-036 Buffer full, then a push and a pop in the same cycle -> no drop, overflow stays 0, output order preserved.
REQ-037 msetting changed 4->3 mid-stream, then sync_reset pulsed for 1 cycle mid-stream -> phase restarts at 0 in both cases, m_axis_tvalid=0 the cycle after reset, and the first post-reset beat emerges 2 cycles after its input.

Source files
------------

// File: rtl/cic_decim_scale_m256_pkg.sv
// cic_decim_scale_m256_pkg: shared channelizer widths, shift limit and saturation bounds
package cic_decim_scale_m256_pkg;
  localparam int W_MID = 49;
  localparam int SHIFT_MAX_DEF = 32;
  function automatic logic signed [W_MID-1:0] sat_hi(input int ow);
    return (W_MID'(1) << (ow - 1)) - W_MID'(1);
  endfunction
  function automatic logic signed [W_MID-1:0] sat_lo(input int ow);
    return ~sat_hi(ow);
  endfunction
endpackage

// File: rtl/axis_skid2.sv
// axis_skid2: 2-entry output FIFO, head entry drives the stream, drops pushes when full and not popping
module axis_skid2 #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_drop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready
);
  logic [1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_d0, r_d1;
  logic w_pop, w_push;
  logic [1:0] w_cnt_n;
  always_comb begin
    o_valid = r_cnt != 2'd0;
    o_data = o_valid ? r_d0 : '0;
    w_pop = o_valid && i_ready;
    w_push = i_valid && (r_cnt != 2'd2 || w_pop);
    o_drop = i_valid && !w_push;
    w_cnt_n = r_cnt + 2'(w_push) - 2'(w_pop);
  end
  always_ff @(posedge clk) begin
    if (sync_reset) r_cnt <= 2'd0;
    else r_cnt <= w_cnt_n;
  end
  // r_d0 is always the head; r_d1 only holds the second entry when two are queued
  always_ff @(posedge clk) begin
    r_d0 <= w_pop ? ((r_cnt == 2'd2) ? r_d1 : i_data) : ((r_cnt == 2'd0) ? i_data : r_d0);
    r_d1 <= (w_push && (r_cnt == 2'd2 || (r_cnt == 2'd1 && !w_pop))) ? i_data : r_d1;
  end
endmodule

// File: rtl/cic_decim_scale_m256.sv
// cic_decim_scale_m256: CIC output decimator with rounding shift, saturation and 2-entry output buffer
module cic_decim_scale_m256
  import cic_decim_scale_m256_pkg::*;
#(
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT_MAX = SHIFT_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic [8:0]           msetting,
  input  logic [5:0]           shift,
  input  logic                 s_axis_tvalid,
  input  logic [47:0]          s_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  input  logic                 m_axis_tready,
  output logic                 overflow,
  output logic                 sat_flag
);
  localparam logic signed [W_MID-1:0] L_HI = sat_hi(OUT_WIDTH);
  localparam logic signed [W_MID-1:0] L_LO = sat_lo(OUT_WIDTH);
  logic [8:0] r_phase, r_mset;
  logic r_v1;
  logic signed [W_MID-1:0] r_s1;
  logic [8:0] w_mod, w_ph, w_ph_inc, w_ph_n;
  logic w_keep, w_hi, w_lo, w_drop;
  logic [5:0] w_sh;
  logic signed [W_MID-1:0] w_ext, w_sum, w_s1;
  logic [OUT_WIDTH-1:0] w_s2;
  // a changed msetting forces phase 0 so the first beat under the new factor is kept
  always_comb begin
    w_mod = (msetting <= 9'd1) ? 9'd1 : msetting;
    w_ph = (msetting != r_mset) ? 9'd0 : r_phase;
    w_ph_inc = w_ph + 9'd1;
    w_ph_n = !s_axis_tvalid ? w_ph : (w_ph_inc == w_mod) ? 9'd0 : w_ph_inc;
    w_keep = s_axis_tvalid && (w_ph == 9'd0);
    w_sh = (shift > 6'(SHIFT_MAX)) ? 6'(SHIFT_MAX) : shift;
    w_ext = {s_axis_tdata[47], s_axis_tdata};
    w_sum = w_ext + (W_MID'(1) << (w_sh - 6'd1));
    w_s1 = (w_sh == 6'd0) ? w_ext : (w_sum >>> w_sh);
    w_hi = r_s1 > L_HI;
    w_lo = r_s1 < L_LO;
    w_s2 = w_hi ? L_HI[OUT_WIDTH-1:0] : w_lo ? L_LO[OUT_WIDTH-1:0] : r_s1[OUT_WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    r_mset <= msetting;
    r_s1 <= w_s1;
    if (sync_reset) begin
      r_phase <= 9'd0;
      r_v1 <= 1'b0;
      overflow <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      r_phase <= w_ph_n;
      r_v1 <= w_keep;
      overflow <= overflow | w_drop;
      sat_flag <= sat_flag | (r_v1 && !w_drop && (w_hi || w_lo));
    end
  end
  // the buffer entry register is the saturation stage's output register
  axis_skid2 #(.DATA_WIDTH(OUT_WIDTH)) u_buf (
    .clk(clk),
    .sync_reset(sync_reset),
    .i_valid(r_v1),
    .i_data(w_s2),
    .o_drop(w_drop),
    .o_valid(m_axis_tvalid),
    .o_data(m_axis_tdata),
    .i_ready(m_axis_tready)
  );
endmodule

// File: tb/tb_cic_decim_scale_m256.sv
// tb_cic_decim_scale_m256: directed checks of decimation, rounding, saturation, buffering and reset
module tb_cic_decim_scale_m256;
  logic clk = 1'b0;
  logic sync_reset = 1'b1;
  logic [8:0] msetting = 9'd1;
  logic [5:0] shift = 6'd0;
  logic s_axis_tvalid = 1'b0;
  logic [47:0] s_axis_tdata = '0;
  logic m_axis_tvalid;
  logic [15:0] m_axis_tdata;
  logic m_axis_tready = 1'b1;
  logic overflow, sat_flag;
  int total = 0;
  int bad = 0;

  cic_decim_scale_m256 dut (
    .clk(clk),
    .sync_reset(sync_reset),
    .msetting(msetting),
    .shift(shift),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tready(m_axis_tready),
    .overflow(overflow),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive one cycle (beat if v), then check the stream output seen after that edge
  task automatic step(input logic v, input logic [47:0] d, input logic ev, input logic [15:0] ed, input string tag);
    s_axis_tvalid = v;
    s_axis_tdata = d;
    tick();
    s_axis_tvalid = 1'b0;
    chk({tag, "_v"}, 48'(m_axis_tvalid), 48'(ev));
    if (ev) chk({tag, "_d"}, 48'(m_axis_tdata), 48'(ed));
  endtask

  task automatic do_reset();
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_v", 48'(m_axis_tvalid), 48'd0);
    chk("rst_d", 48'(m_axis_tdata), 48'd0);
    chk("rst_ovf", 48'(overflow), 48'd0);
    chk("rst_sat", 48'(sat_flag), 48'd0);
    sync_reset = 1'b0;
    msetting = 9'd4;
    tick();
    // decimate by 4: inputs 0..15 keep 0,4,8,12, each visible 2 cycles after its input
    for (int i = 0; i <= 16; i++)
      step(i < 16, 48'(i), (i >= 1) && ((i - 1) % 4 == 0), 16'(i - 1), "dec4");
    // rounding with shift 4, pass-through factor
    msetting = 9'd1;
    shift = 6'd4;
    step(1'b1, 48'd24, 1'b0, 16'd0, "rnd0");
    step(1'b1, 48'd23, 1'b1, 16'd2, "rnd24");
    step(1'b1, -48'sd24, 1'b1, 16'd1, "rnd23");
    step(1'b1, -48'sd25, 1'b1, 16'hFFFF, "rndm24");
    step(1'b0, 48'd0, 1'b1, 16'hFFFE, "rndm25");
    step(1'b0, 48'd0, 1'b0, 16'd0, "rnd_idle");
    // saturation
    shift = 6'd0;
    chk("sat_pre", 48'(sat_flag), 48'd0);
    step(1'b1, 48'd40000, 1'b0, 16'd0, "sat0");
    step(1'b1, -48'sd40000, 1'b1, 16'h7FFF, "sat_hi");
    step(1'b0, 48'd0, 1'b1, 16'h8000, "sat_lo");
    chk("sat_flag", 48'(sat_flag), 48'd1);
    step(1'b0, 48'd0, 1'b0, 16'd0, "sat_idle");
    // full buffer with no pop: third sample dropped
    chk("ovf_pre", 48'(overflow), 48'd0);
    m_axis_tready = 1'b0;
    step(1'b1, 48'd100, 1'b0, 16'd0, "full0");
    step(1'b1, 48'd200, 1'b1, 16'd100, "full1");
    step(1'b1, 48'd300, 1'b1, 16'd100, "full2");
    step(1'b0, 48'd0, 1'b1, 16'd100, "full3");
    chk("ovf_set", 48'(overflow), 48'd1);
    step(1'b0, 48'd0, 1'b1, 16'd100, "hold");
    m_axis_tready = 1'b1;
    step(1'b0, 48'd0, 1'b1, 16'd200, "drain1");
    step(1'b0, 48'd0, 1'b0, 16'd0, "drain2");
    chk("ovf_sticky", 48'(overflow), 48'd1);
    chk("sat_sticky", 48'(sat_flag), 48'd1);
    // full buffer with simultaneous push and pop
    do_reset();
    chk("rst2_ovf", 48'(overflow), 48'd0);
    chk("rst2_sat", 48'(sat_flag), 48'd0);
    m_axis_tready = 1'b0;
    step(1'b1, 48'd1, 1'b0, 16'd0, "pp0");
    step(1'b1, 48'd2, 1'b1, 16'd1, "pp1");
    step(1'b1, 48'd3, 1'b1, 16'd1, "pp2");
    m_axis_tready = 1'b1;
    step(1'b0, 48'd0, 1'b1, 16'd2, "pp_both");
    chk("pp_ovf", 48'(overflow), 48'd0);
    step(1'b0, 48'd0, 1'b1, 16'd3, "pp_last");
    step(1'b0, 48'd0, 1'b0, 16'd0, "pp_empty");
    chk("pp_ovf_end", 48'(overflow), 48'd0);
    // msetting change 4->3, then reset pulse mid-stream
    msetting = 9'd4;
    do_reset();
    step(1'b1, 48'd10, 1'b0, 16'd0, "m4_10");
    step(1'b1, 48'd11, 1'b1, 16'd10, "m4_11");
    step(1'b1, 48'd12, 1'b0, 16'd0, "m4_12");
    step(1'b1, 48'd13, 1'b0, 16'd0, "m4_13");
    step(1'b1, 48'd14, 1'b0, 16'd0, "m4_14");
    step(1'b1, 48'd15, 1'b1, 16'd14, "m4_15");
    msetting = 9'd3;
    step(1'b1, 48'd20, 1'b0, 16'd0, "m3_20");
    step(1'b1, 48'd21, 1'b1, 16'd20, "m3_21");
    step(1'b1, 48'd22, 1'b0, 16'd0, "m3_22");
    step(1'b1, 48'd23, 1'b0, 16'd0, "m3_23");
    sync_reset = 1'b1;
    step(1'b1, 48'd24, 1'b0, 16'd0, "mrst");
    chk("mrst_d", 48'(m_axis_tdata), 48'd0);
    sync_reset = 1'b0;
    step(1'b1, 48'd25, 1'b0, 16'd0, "post0");
    step(1'b0, 48'd0, 1'b1, 16'd25, "post1");
    step(1'b0, 48'd0, 1'b0, 16'd0, "post2");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
